// File: rtl/fsm_5_19_bit_tx_pkg.sv
// Shared types and constants for the serial bit-stream transmitter feeding the 5.19 sequence FSM.
package fsm_5_19_bit_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } tx_state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int GAP_MAX   = 15;

    // Bit-count width: must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/fsm_5_19_bit_tx.sv
// Parallel-load, MSB-first serial transmitter with pause and a post-word idle gap.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for a word; load_ready high outside reset
//  SHIFT | presenting payload bits, one per un-paused clock
//  GAP   | idle bubble of GAP_CYCLES clocks before accepting again
module fsm_5_19_bit_tx
    import fsm_5_19_bit_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              data_in,
    input  logic [cnt_width(WIDTH)-1:0]   nbits_in,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic                          pause,
    output logic                          x_out,
    output logic                          x_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
    localparam logic [3:0]    GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    tx_state_e        state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic [CW-1:0]    n_eff;
    logic [WIDTH-1:0] aligned;
    logic             accept;

    assign load_ready = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);
    assign accept     = load_valid && load_ready;

    always_comb begin
        n_eff = nbits_in;
        if (nbits_in == '0 || nbits_in > WIDTH_C)
            n_eff = WIDTH_C;
    end

    // Left-justify the active field so the next bit is always sreg[WIDTH-1].
    assign aligned = data_in << (WIDTH_C - n_eff);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == '0) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bit_cnt counts bits still to present; the first bit goes out on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= 4'd0;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_out   <= aligned[WIDTH-1];
                        x_valid <= 1'b1;
                        sreg    <= aligned << 1;
                        bit_cnt <= n_eff - CW'(1);
                        done    <= (n_eff == CW'(1));
                    end
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        gap_cnt <= GAP_LOAD;
                    end else if (!pause) begin
                        x_out   <= sreg[WIDTH-1];
                        x_valid <= 1'b1;
                        sreg    <= sreg << 1;
                        bit_cnt <= bit_cnt - CW'(1);
                        done    <= (bit_cnt == CW'(1));
                    end
                end
                GAP: begin
                    if (gap_cnt != 4'd0)
                        gap_cnt <= gap_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_5_19_bit_tx.sv
// Directed bench: instance a (GAP_CYCLES=1) and instance b (GAP_CYCLES=0) with a per-bit scoreboard.
module tb_fsm_5_19_bit_tx;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  data_a, data_b;
    logic [CW-1:0] nb_a, nb_b;
    logic          lv_a, lv_b, pause_a, pause_b;
    logic          lr_a, xo_a, xv_a, busy_a, done_a;
    logic          lr_b, xo_b, xv_b, busy_b, done_b;

    int vecs = 0;
    int errs = 0;
    int done_cnt_b = 0;
    logic [1:0] qa[$];
    logic [1:0] qb[$];

    fsm_5_19_bit_tx #(.WIDTH(W), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .nbits_in(nb_a),
        .load_valid(lv_a), .load_ready(lr_a), .pause(pause_a),
        .x_out(xo_a), .x_valid(xv_a), .busy(busy_a), .done(done_a)
    );

    fsm_5_19_bit_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .nbits_in(nb_b),
        .load_valid(lv_b), .load_ready(lr_b), .pause(pause_b),
        .x_out(xo_b), .x_valid(xv_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bits of a word, MSB of the active field first; done flags the last.
    task automatic push(input int sel, input logic [W-1:0] d, input int n);
        int ne;
        ne = (n == 0 || n > W) ? W : n;
        for (int i = ne - 1; i >= 0; i--) begin
            if (sel == 0) qa.push_back({d[i], 1'(i == 0)});
            else          qb.push_back({d[i], 1'(i == 0)});
        end
    endtask

    task automatic mon();
        logic [1:0] e;
        if (xv_a) begin
            if (qa.size() == 0) chk("a_extra_bit", 32'(xv_a), 0);
            else begin
                e = qa.pop_front();
                chk("a_bit", 32'(xo_a), 32'(e[1]));
                chk("a_done", 32'(done_a), 32'(e[0]));
            end
        end else begin
            chk("a_quiet", {30'd0, xo_a, done_a}, 0);
        end
        if (xv_b) begin
            if (qb.size() == 0) chk("b_extra_bit", 32'(xv_b), 0);
            else begin
                e = qb.pop_front();
                chk("b_bit", 32'(xo_b), 32'(e[1]));
                chk("b_done", 32'(done_b), 32'(e[0]));
            end
        end else begin
            chk("b_quiet", {30'd0, xo_b, done_b}, 0);
        end
        if (done_b) done_cnt_b++;
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
    endtask

    task automatic send_a(input logic [W-1:0] d, input int n);
        data_a = d;
        nb_a   = CW'(n);
        lv_a   = 1'b1;
        push(0, d, n);
    endtask

    initial begin
        rst = 1'b1;
        data_a = '0; data_b = '0; nb_a = '0; nb_b = '0;
        lv_a = 1'b0; lv_b = 1'b0; pause_a = 1'b0; pause_b = 1'b0;

        cyc(); cyc();
        chk("rst_load_ready", 32'(lr_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_x_valid", 32'(xv_a), 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_ready_a", 32'(lr_a), 1);
        chk("post_rst_ready_b", 32'(lr_b), 1);

        // 0x0B, n=4: bits 1,0,1,1; gap on cycle 5, ready on cycle 6
        send_a(8'h0B, 4);
        cyc(); lv_a = 1'b0;
        repeat (3) cyc();
        cyc();
        chk("w1_gap_ready", 32'(lr_a), 0);
        chk("w1_gap_busy", 32'(busy_a), 1);
        cyc();
        chk("w1_ready_c6", 32'(lr_a), 1);
        chk("w1_drained", qa.size(), 0);

        // nbits 0 and 9 both mean full width
        for (int k = 0; k < 2; k++) begin
            send_a(8'hA5, (k == 0) ? 0 : 9);
            cyc(); lv_a = 1'b0;
            repeat (7) cyc();
            cyc();
            cyc();
            chk("a5_ready", 32'(lr_a), 1);
            chk("a5_drained", qa.size(), 0);
        end

        // single-bit word
        send_a(8'h01, 1);
        cyc(); lv_a = 1'b0;
        cyc();
        chk("n1_gap_ready", 32'(lr_a), 0);
        cyc();
        chk("n1_ready", 32'(lr_a), 1);

        // 0xF0 with pause over the 3rd and 4th edges
        send_a(8'hF0, 8);
        cyc(); lv_a = 1'b0;
        cyc(); pause_a = 1'b1;
        cyc(); chk("pause_c3_valid", 32'(xv_a), 0);
        cyc(); chk("pause_c4_valid", 32'(xv_a), 0);
        pause_a = 1'b0;
        repeat (5) cyc();
        cyc(); chk("pause_done_c10", 32'(done_a), 1);
        cyc(); cyc();
        chk("pause_drained", qa.size(), 0);

        // pause on the last bit delays done
        send_a(8'h02, 2);
        cyc(); lv_a = 1'b0; pause_a = 1'b1;
        cyc(); chk("last_pause_done", 32'(done_a), 0);
        pause_a = 1'b0;
        cyc(); chk("last_done", 32'(done_a), 1);
        cyc(); cyc();
        chk("last_drained", qa.size(), 0);

        // back-to-back on b with no gap: exactly one bubble, second word changed while busy
        data_b = 8'h3C; nb_b = CW'(4); lv_b = 1'b1;
        push(1, 8'h3C, 4);
        push(1, 8'h05, 3);
        cyc();
        data_b = 8'h05; nb_b = CW'(3);
        repeat (3) cyc();
        cyc();
        chk("b2b_bubble_valid", 32'(xv_b), 0);
        chk("b2b_bubble_ready", 32'(lr_b), 1);
        cyc(); lv_b = 1'b0;
        chk("b2b_word2_start", 32'(xv_b), 1);
        cyc(); cyc();
        cyc();
        chk("b2b_done_pulses", done_cnt_b, 2);
        chk("b2b_drained", qb.size(), 0);
        chk("b2b_idle", 32'(busy_b), 0);

        // reset on the 3rd bit of 0xFF
        data_a = 8'hFF; nb_a = CW'(8); lv_a = 1'b1;
        qa.push_back(2'b10);
        qa.push_back(2'b10);
        cyc(); lv_a = 1'b0;
        cyc(); rst = 1'b1;
        cyc();
        chk("rst_mid_valid", 32'(xv_a), 0);
        chk("rst_mid_ready", 32'(lr_a), 0);
        chk("rst_mid_done", 32'(done_a), 0);
        cyc();
        chk("rst_hold_ready", 32'(lr_a), 0);
        rst = 1'b0;
        cyc();
        chk("rst_release_ready", 32'(lr_a), 1);
        chk("rst_release_busy", 32'(busy_a), 0);
        send_a(8'h6A, 8);
        cyc(); lv_a = 1'b0;
        repeat (7) cyc();
        cyc(); cyc();
        chk("post_rst_drained", qa.size(), 0);
        chk("post_rst_ready", 32'(lr_a), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fsm_5_19_bit_tx.md
Name: fsm_5_19_bit_tx

Overview:
- Serial bit-stream transmitter that produces the x_in stream consumed by the 5.19 Mealy sequence machine.
- Accepts a parallel word plus a bit count over a valid/ready handshake.
- Shifts the active field out MSB-first, one bit per clock, with an optional pause and an inter-word idle gap.
- Sits upstream of the FSM as its stimulus/transmit end. x_out connects to x_in; x_valid qualifies it for monitors.

Parameters:
- WIDTH, 8, maximum word length in bits (2..32).
- GAP_CYCLES, 1, idle cycles inserted after each word before load_ready reasserts (0..15).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  WIDTH  parallel word; only bits [nbits-1:0] are transmitted.
- nbits_in  input  $clog2(WIDTH)+1  bits to send; 0 means WIDTH; values >WIDTH are clamped to WIDTH.
- load_valid  input  1  word/count presented.
- load_ready  output  1  transmitter can accept a word.
- pause  input  1  freezes shifting while high.
- x_out  output  1  serial bit to FSM x_in.
- x_valid  output  1  x_out carries a payload bit this cycle.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse on the last bit of a word.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port rst. Polarity and synchronicity are fixed.
- Reset values:
  - state=IDLE; x_out=0, x_valid=0, done=0; shift register and counters 0.
  - load_ready=0 while rst=1. load_ready=1 in the first cycle after rst deasserts.
- Registers: x_out, x_valid and done are registered. load_ready=(state==IDLE)&&!rst and busy are decoded from state.
- IDLE:
  - x_out=0, x_valid=0.
  - Handshake fires on the posedge where load_valid&&load_ready.
  - Captures data_in into shift register and n=nbits_in (0/oversize -> WIDTH) into bit counter; state -> SHIFT.
  - load_valid outside IDLE is ignored; upstream holds data until load_ready.
- SHIFT:
  - First payload bit data_in[n-1] appears with x_valid=1 in the cycle after the accepting edge (latency 1).
  - Each subsequent un-paused cycle presents the next lower bit, ending with data_in[0].
  - pause=1 at an edge: counter and shift register hold; x_valid=0 and x_out=0 next cycle. No bit is lost or duplicated.
  - done=1 in the same cycle as the last bit (x_valid=1).
  - After the last bit: state -> GAP if GAP_CYCLES>0, else -> IDLE.
- GAP:
  - x_out=0, x_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
  - pause has no effect in GAP or IDLE.
- Back-to-back with GAP_CYCLES=0: load_ready is high the cycle after the last bit. Accept there gives exactly one x_valid=0 bubble between words.
- n=1: single bit, done coincides with it.
- Reset mid-word or mid-gap:
  - Abort immediately at that edge; outputs return to reset values.
  - No done pulse; remaining bits are discarded.
- pause on the last bit: done waits until the last bit is actually presented.

Decomposition:
- Shared package:
  - State encoding IDLE=2'b00, SHIFT=2'b01, GAP=2'b10; default/illegal -> IDLE.
  - Function for the count-width computation.
  - WIDTH bound constants.
- Single module; no sub-module is warranted (shift register, bit counter and gap counter are small in-module processes).
- Three processes: state register, next-state, registered outputs.

Test Plan:
- WIDTH=8, GAP=1:
  - Reset 2 cycles, then load data_in=8'h0B, nbits_in=4.
  - Expect x_out=1,0,1,1 with x_valid=1 on cycles 1-4 after accept, done on cycle 4, one gap cycle, load_ready=1 on cycle 6.
- Integration into the 5.19 FSM (starts S0), same word:
  - Expect FSM y_out=1,0,1,1.
  - Expect state sequence S4,S2,S0,S4.
- nbits_in=0, data_in=8'hA5:
  - Expect 8 bits 1,0,1,0,0,1,0,1, done on the 8th.
  - nbits_in=9 gives an identical result.
- pause high for 2 cycles after the 2nd bit of 8'hF0 (n=8):
  - Expect two x_valid=0 cycles, then bits resume 1,1,0,0,0,0.
  - Total 10 cycles from first bit to done.
- GAP_CYCLES=0, two words held valid back-to-back:
  - Expect exactly one bubble cycle between words and two done pulses.
  - Expect load_valid ignored while busy.
- rst asserted on the 3rd bit of 8'hFF, n=8:
  - Expect x_valid=0, x_out=0, no done, load_ready=0 during rst.
  - Expect load_ready=1 the cycle after rst drops; the next word transmits correctly.
